// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Purpose: combinational 1-bit full adder used as the serial arithmetic cell.
// Latency: zero cycles, purely combinational.
// Backpressure: none; outputs follow inputs continuously.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Purpose: bit-serial WIDTH-bit adder, one bit pair per clock LSB first; SERIAL_ADDER_OVF_EN adds signed overflow output ovf.
// Latency: done pulses WIDTH edges after the start edge; one operation per WIDTH+2 cycles.
// Backpressure: start is honoured only in IDLE; starts while busy are dropped, never queued.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    // Holds the WIDTH-1 lower sum bits; the final bit is merged straight into sum.
    logic [WIDTH-2:0] acc;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    fa_cell u_fa (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .c    (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shift_a <= '0;
            shift_b <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shift_a <= a;
                        shift_b <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    acc     <= (WIDTH-1)'({fa_s, acc} >> 1);
                    carry_q <= fa_c;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= {fa_s, acc};
                        cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB at this edge.
                        ovf   <= carry_q ^ fa_c;
`endif
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks;
    int failures;
    int cyc;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation and reports what the DUT did; comparisons live in the callers.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         output logic [W-1:0] o_sum, output logic o_cout, output int lat,
                         output logic busy_ok, output logic done_after, output logic busy_after,
                         output int done_cyc);
        a = ia; b = ib; cin = ic; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ia; b = ~ib; cin = ~ic;
        busy_ok = busy;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            busy_ok = busy_ok & busy;
        end
        done_cyc = cyc;
        o_sum = sum;
        o_cout = cout;
        tick();
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        checks++;
        if ({busy, done, sum, cout} !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] s; logic co, bok, da, ba; int lat, dc;
        do_op(8'h5A, 8'h33, 1'b0, s, co, lat, bok, da, ba, dc);
        checks++;
        if (lat !== W) begin
            failures++;
            $display("FAIL basic_latency edges=%0d expected %0d", lat, W);
        end
        checks++;
        if (s !== 8'h8D || co !== 1'b0) begin
            failures++;
            $display("FAIL basic_sum got %b_%h expected 0_8d", co, s);
        end
        checks++;
        if (bok !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy busy dropped during operation, expected high");
        end
        checks++;
        if (da !== 1'b0 || ba !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse done=%b busy=%b after pulse, expected 0 0", da, ba);
        end
    endtask

    task automatic test_carry_reload();
        logic [W-1:0] s; logic co, bok, da, ba; int lat, dc;
        do_op(8'hFF, 8'h01, 1'b0, s, co, lat, bok, da, ba, dc);
        checks++;
        if (s !== 8'h00 || co !== 1'b1) begin
            failures++;
            $display("FAIL carry_ff_01 got %b_%h expected 1_00", co, s);
        end
        do_op(8'h00, 8'h00, 1'b1, s, co, lat, bok, da, ba, dc);
        checks++;
        if (s !== 8'h01 || co !== 1'b0) begin
            failures++;
            $display("FAIL carry_reload got %b_%h expected 0_01", co, s);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (done) ndone++;
            if (i == 3 || i == 8) begin
                a = 8'hFF; b = 8'hFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL ignore_done_count got %0d expected 1", ndone);
        end
        checks++;
        if (sum !== 8'h30 || cout !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result sum=%h cout=%b busy=%b expected 30 0 0", sum, cout, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s; logic co, bok, da, ba; int lat, dc, ndone;
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== '0) begin
            failures++;
            $display("FAIL midreset_async busy=%b done=%b sum=%h cout=%b expected all 0", busy, done, sum, cout);
        end
        tick(); tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL midreset_no_done active_cycles=%0d expected 0", ndone);
        end
        do_op(8'hAA, 8'h55, 1'b1, s, co, lat, bok, da, ba, dc);
        checks++;
        if (s !== 8'h00 || co !== 1'b1) begin
            failures++;
            $display("FAIL midreset_recover got %b_%h expected 1_00", co, s);
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] s; logic co, bok, da, ba; int lat, dc;
        do_op(8'h7F, 8'h01, 1'b0, s, co, lat, bok, da, ba, dc);
        checks++;
        if (s !== 8'h80 || co !== 1'b0 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_7f_01 got %b_%h ovf=%b expected 0_80 ovf=1", co, s, ovf);
        end
        do_op(8'h80, 8'h80, 1'b0, s, co, lat, bok, da, ba, dc);
        checks++;
        if (s !== 8'h00 || co !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_80_80 got %b_%h ovf=%b expected 1_00 ovf=1", co, s, ovf);
        end
        do_op(8'hFF, 8'h01, 1'b0, s, co, lat, bok, da, ba, dc);
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_ff_01 ovf=%b expected 0", ovf);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] s, ra, rb; logic co, rc, bok, da, ba; int lat, dc, prev_dc;
        logic [W:0] expv;
        prev_dc = -1;
        for (int n = 0; n < 500; n++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            expv = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_op(ra, rb, rc, s, co, lat, bok, da, ba, dc);
            checks++;
            if ({co, s} !== expv) begin
                failures++;
                $display("FAIL sweep_sum op=%0d %h+%h+%b got %h expected %h", n, ra, rb, rc, {co, s}, expv);
            end
            if (prev_dc >= 0) begin
                checks++;
                if (dc - prev_dc !== W + 2) begin
                    failures++;
                    $display("FAIL sweep_spacing op=%0d got %0d cycles expected %0d", n, dc - prev_dc, W + 2);
                end
            end
            prev_dc = dc;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_carry_reload();
        test_ignore_start();
        test_reset_mid();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
